// File: rtl/cc_object_stats_pkg.sv
// Shared definitions for the connected-components object statistics block.
// Holds default label/coordinate/area widths, the background label and the
// controller state encoding used by cc_object_stats.
package cc_object_stats_pkg;

    // Label width; the stats table has 2**WORD_SIZE entries.
    localparam int WORD_SIZE = 8;

    // Stats record field widths.
    localparam int COORD_W = 11;
    localparam int AREA_W  = 20;

    // Label value that marks background pixels.
    localparam int BG_LABEL = 0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/cc_stats_entry_update.sv
// Purpose: folds one pixel (x, y) into a label's stats entry (area + bounding box).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports: area/min/max entry in, current pixel x/y in, updated entry out.
// The area count saturates at all-ones instead of wrapping.
module cc_stats_entry_update #(
    parameter int COORD_W = cc_object_stats_pkg::COORD_W,
    parameter int AREA_W  = cc_object_stats_pkg::AREA_W
) (
    input  logic [AREA_W-1:0]  area_in,
    input  logic [COORD_W-1:0] min_x_in,
    input  logic [COORD_W-1:0] max_x_in,
    input  logic [COORD_W-1:0] min_y_in,
    input  logic [COORD_W-1:0] max_y_in,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [AREA_W-1:0]  area_out,
    output logic [COORD_W-1:0] min_x_out,
    output logic [COORD_W-1:0] max_x_out,
    output logic [COORD_W-1:0] min_y_out,
    output logic [COORD_W-1:0] max_y_out
);

    always_comb begin
        area_out  = (&area_in) ? area_in : area_in + 1'b1;
        min_x_out = (x < min_x_in) ? x : min_x_in;
        max_x_out = (x > max_x_in) ? x : max_x_in;
        min_y_out = (y < min_y_in) ? y : min_y_in;
        max_y_out = (y > max_y_in) ? y : max_y_in;
    end

endmodule

// File: rtl/cc_object_stats.sv
// Purpose: per-label area/bounding-box accumulation over a frame, drained as records at end of frame.
// Latency: 1 cycle per pixel in ACCUM; first record 1 cycle after the scan reaches it, at most 1 record per 2 cycles.
// Backpressure: in_ready low outside ACCUM; the drain scan stalls while rec_valid && !rec_ready, holding rec_* stable.
//
// Ports: clk, reset (async, active low); pixel input en/label/in_ready;
// record output rec_valid/rec_ready/rec_label/rec_min_x/rec_max_x/rec_min_y/rec_max_y/rec_area;
// done pulses for one cycle when the drain finishes.
// Build option: define CC_OBJECT_STATS_MIN_AREA_EN to drop records whose area is below MIN_AREA.
module cc_object_stats #(
    parameter int FRAME_WIDTH    = 297,
    parameter int FRAME_HEIGHT   = 1,
    parameter int WORD_SIZE      = cc_object_stats_pkg::WORD_SIZE,
    parameter int NUM_LABELS     = 2 ** WORD_SIZE,
    parameter int CONFLICT_LABEL = 255,
    parameter int COORD_W        = cc_object_stats_pkg::COORD_W,
    parameter int AREA_W         = cc_object_stats_pkg::AREA_W,
    parameter int MIN_AREA       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WORD_SIZE-1:0] label,
    output logic                 in_ready,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [WORD_SIZE-1:0] rec_label,
    output logic [COORD_W-1:0]   rec_min_x,
    output logic [COORD_W-1:0]   rec_max_x,
    output logic [COORD_W-1:0]   rec_min_y,
    output logic [COORD_W-1:0]   rec_max_y,
    output logic [AREA_W-1:0]    rec_area,
    output logic                 done
);

    import cc_object_stats_pkg::*;

`ifdef CC_OBJECT_STATS_MIN_AREA_EN
    localparam bit MIN_AREA_EN = 1'b1;
`else
    localparam bit MIN_AREA_EN = 1'b0;
`endif

    localparam logic [COORD_W-1:0]   X_LAST       = COORD_W'(FRAME_WIDTH - 1);
    localparam logic [COORD_W-1:0]   Y_LAST       = COORD_W'(FRAME_HEIGHT - 1);
    localparam logic [WORD_SIZE-1:0] LBL_BG       = WORD_SIZE'(BG_LABEL);
    localparam logic [WORD_SIZE-1:0] LBL_CONFLICT = WORD_SIZE'(CONFLICT_LABEL);
    localparam logic [WORD_SIZE-1:0] IDX_LAST     = WORD_SIZE'(NUM_LABELS - 1);
    // Smallest area that produces a record; area >= 1 is simply "non-empty".
    localparam logic [AREA_W-1:0]    AREA_FLOOR   = MIN_AREA_EN ? AREA_W'(MIN_AREA) : AREA_W'(1);

    state_t state_q, state_d;

    logic [WORD_SIZE-1:0] clr_idx;
    logic [WORD_SIZE-1:0] scan_idx;
    logic                 scan_done;
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;

    // Stats table, register based so the same-cycle read-modify-write
    // handles back-to-back pixels of one label without forwarding.
    logic [AREA_W-1:0]  tbl_area  [NUM_LABELS];
    logic [COORD_W-1:0] tbl_min_x [NUM_LABELS];
    logic [COORD_W-1:0] tbl_max_x [NUM_LABELS];
    logic [COORD_W-1:0] tbl_min_y [NUM_LABELS];
    logic [COORD_W-1:0] tbl_max_y [NUM_LABELS];

    logic [AREA_W-1:0]  upd_area;
    logic [COORD_W-1:0] upd_min_x, upd_max_x, upd_min_y, upd_max_y;

    logic pix_acc;
    logic pix_upd;
    logic pix_last;
    logic scan_hit;
    logic drain_end;

    assign in_ready  = (state_q == ST_ACCUM);
    assign pix_acc   = en && in_ready;
    assign pix_upd   = pix_acc && (label != LBL_BG) && (label != LBL_CONFLICT);
    assign pix_last  = (x_q == X_LAST) && (y_q == Y_LAST);
    assign scan_hit  = (scan_idx != LBL_CONFLICT) && (tbl_area[scan_idx] >= AREA_FLOOR);
    assign drain_end = (state_q == ST_DRAIN) && scan_done && !rec_valid;
    assign done      = drain_end;

    cc_stats_entry_update #(
        .COORD_W (COORD_W),
        .AREA_W  (AREA_W)
    ) u_entry_update (
        .area_in   (tbl_area[label]),
        .min_x_in  (tbl_min_x[label]),
        .max_x_in  (tbl_max_x[label]),
        .min_y_in  (tbl_min_y[label]),
        .max_y_in  (tbl_max_y[label]),
        .x         (x_q),
        .y         (y_q),
        .area_out  (upd_area),
        .min_x_out (upd_min_x),
        .max_x_out (upd_max_x),
        .min_y_out (upd_min_y),
        .max_y_out (upd_max_y)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_idx == IDX_LAST)   state_d = ST_ACCUM;
            ST_ACCUM: if (pix_acc && pix_last)   state_d = ST_DRAIN;
            ST_DRAIN: if (drain_end)             state_d = ST_CLEAR;
            default:                             state_d = ST_CLEAR;
        endcase
    end

    // Table contents need no reset: CLEAR rewrites every entry before ACCUM.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            tbl_area[clr_idx]  <= '0;
            tbl_min_x[clr_idx] <= '1;
            tbl_max_x[clr_idx] <= '0;
            tbl_min_y[clr_idx] <= '1;
            tbl_max_y[clr_idx] <= '0;
        end else if (pix_upd) begin
            tbl_area[label]  <= upd_area;
            tbl_min_x[label] <= upd_min_x;
            tbl_max_x[label] <= upd_max_x;
            tbl_min_y[label] <= upd_min_y;
            tbl_max_y[label] <= upd_max_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_idx   <= '0;
            scan_idx  <= '0;
            scan_done <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rec_valid <= 1'b0;
            rec_label <= '0;
            rec_min_x <= '0;
            rec_max_x <= '0;
            rec_min_y <= '0;
            rec_max_y <= '0;
            rec_area  <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // Wraps to 0 on the last entry, ready for the next CLEAR.
                    clr_idx <= clr_idx + 1'b1;
                    x_q     <= '0;
                    y_q     <= '0;
                end
                ST_ACCUM: begin
                    if (pix_acc) begin
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                        if (pix_last) begin
                            // Label 0 is background, so the scan starts at 1.
                            scan_idx  <= WORD_SIZE'(1);
                            scan_done <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rec_valid) begin
                        if (rec_ready) begin
                            rec_valid <= 1'b0;
                        end
                    end else if (!scan_done) begin
                        if (scan_hit) begin
                            rec_valid <= 1'b1;
                            rec_label <= scan_idx;
                            rec_min_x <= tbl_min_x[scan_idx];
                            rec_max_x <= tbl_max_x[scan_idx];
                            rec_min_y <= tbl_min_y[scan_idx];
                            rec_max_y <= tbl_max_y[scan_idx];
                            rec_area  <= tbl_area[scan_idx];
                        end
                        scan_idx <= scan_idx + 1'b1;
                        if (scan_idx == IDX_LAST) begin
                            scan_done <= 1'b1;
                        end
                    end else begin
                        clr_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
